// File: rtl/pc_ctrl_pkg.sv
// Shared op encodings, FSM state type and the jump-target table
// for the next-PC control unit.
package pc_ctrl_pkg;

  localparam logic [3:0] OP_BZ   = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_CALL = 4'h3;
  localparam logic [3:0] OP_RET  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Upper nibble = idx[3:0]+1, bit 3 = idx[4]; e.g. idx 3 -> 0x40
  function automatic logic [7:0] lut_target(input logic [4:0] idx);
    return {idx[3:0] + 4'd1, idx[4], 3'b000};
  endfunction

endpackage

// File: rtl/pc_ctrl_ret_stack.sv
// Return-address stack: DEPTH x 8 entries, push/pop at the edge,
// combinational top-of-stack; entries are not cleared on pop.
module ret_stack #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       Init,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] top,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] sp_q;
  logic [PW-1:0] sp_d;
  logic [AW-1:0] wr_a;
  logic [AW-1:0] rd_a;
  logic          do_push;
  logic          do_pop;

  assign full    = (sp_q == PW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_a    = AW'(sp_q);
  assign rd_a    = AW'(sp_q - PW'(1));
  assign top     = empty ? 8'h00 : mem_q[rd_a];

  always_comb begin
    sp_d = sp_q;
    if (do_push)
      sp_d = sp_q + PW'(1);
    else if (do_pop)
      sp_d = sp_q - PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (Init)
      sp_q <= '0;
    else
      sp_q <= sp_d;
  end

  always_ff @(posedge CLK) begin
    if (!Init && do_push)
      mem_q[wr_a] <= din;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC control: decodes control ops, drives Branch/Target/Halt to
// the fetch unit and sequences IDLE -> RUN -> HALTED.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       Init,
  input  logic       Start,
  input  logic [7:0] PC,
  input  logic [8:0] Instr,
  input  logic       Zero,
  output logic       Branch,
  output logic [7:0] Target,
  output logic       Halt,
  output logic       Done,
  output logic       Fault
);

  ctrl_state_t state_q;
  logic        done_q;
  logic        fault_q;

  logic [3:0] op;
  logic [4:0] idx;
  logic       br_d;
  logic [7:0] tgt_d;
  logic       halt_d;
  logic       push;
  logic       pop;
  logic       stop;
  logic       flt;
  logic [7:0] top;
  logic       full;
  logic       empty;

  assign op  = Instr[8:5];
  assign idx = Instr[4:0];

  ret_stack #(
    .DEPTH(DEPTH)
  ) u_stack (
    .CLK  (CLK),
    .Init (Init),
    .push (push),
    .pop  (pop),
    .din  (PC + 8'd1),
    .top  (top),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    br_d   = 1'b0;
    tgt_d  = 8'h00;
    halt_d = 1'b1;
    push   = 1'b0;
    pop    = 1'b0;
    stop   = 1'b0;
    flt    = 1'b0;
    if (!Init && state_q == RUN) begin
      halt_d = 1'b0;
      case (op)
        OP_BZ: begin
          if (Zero) begin
            br_d  = 1'b1;
            tgt_d = lut_target(idx);
          end
        end
        OP_JMP: begin
          br_d  = 1'b1;
          tgt_d = lut_target(idx);
        end
        OP_CALL: begin
          if (full) begin
            halt_d = 1'b1;
            stop   = 1'b1;
            flt    = 1'b1;
          end else begin
            br_d  = 1'b1;
            tgt_d = lut_target(idx);
            push  = 1'b1;
          end
        end
        OP_RET: begin
          if (empty) begin
            halt_d = 1'b1;
            stop   = 1'b1;
            flt    = 1'b1;
          end else begin
            br_d  = 1'b1;
            tgt_d = top;
            pop   = 1'b1;
          end
        end
        OP_HALT: begin
          halt_d = 1'b1;
          stop   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Branch = br_d;
  assign Target = tgt_d;
  assign Halt   = halt_d;
  assign Done   = done_q;
  assign Fault  = fault_q;

  always_ff @(posedge CLK) begin
    if (Init) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start)
            state_q <= RUN;
        end
        RUN: begin
          if (stop) begin
            state_q <= HALTED;
            done_q  <= 1'b1;
          end
          if (flt)
            fault_q <= 1'b1;
        end
        HALTED: ;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios then random ops, compared
// each cycle against a queue-based model that also plays fetch unit.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [3:0] NOP = 4'h0;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic       CLK = 1'b0;
  logic       Init = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] PC = 8'h00;
  logic [8:0] Instr = 9'h000;
  logic       Zero = 1'b0;
  logic       Branch;
  logic [7:0] Target;
  logic       Halt;
  logic       Done;
  logic       Fault;

  pc_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .Init  (Init),
    .Start (Start),
    .PC    (PC),
    .Instr (Instr),
    .Zero  (Zero),
    .Branch(Branch),
    .Target(Target),
    .Halt  (Halt),
    .Done  (Done),
    .Fault (Fault)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  int         ms = M_IDLE;
  logic [7:0] stk[$];
  bit         mfault = 1'b0;
  bit         mdone = 1'b0;
  logic [7:0] mpc = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lut(input int i);
    return 8'((((i % 16) + 1) % 16) * 16 + (i / 16) * 8);
  endfunction

  // One instruction cycle: drive at negedge, check, advance at posedge.
  task automatic cyc(input bit ini, input bit st, input logic [3:0] op,
                     input logic [4:0] idx, input bit z);
    bit         eb, eh, push, pop, stop, flt;
    logic [7:0] et;
    Init = ini; Start = st; Instr = {op, idx}; Zero = z; PC = mpc;
    eb = 0; eh = 1; et = 8'h00;
    push = 0; pop = 0; stop = 0; flt = 0;
    if (!ini && ms == M_RUN) begin
      eh = 0;
      if ((op == OP_BZ && z) || op == OP_JMP) begin
        eb = 1; et = lut(int'(idx));
      end else if (op == OP_CALL) begin
        if (stk.size() < DEPTH) begin
          eb = 1; et = lut(int'(idx)); push = 1;
        end else begin
          eh = 1; stop = 1; flt = 1;
        end
      end else if (op == OP_RET) begin
        if (stk.size() > 0) begin
          eb = 1; et = stk[$]; pop = 1;
        end else begin
          eh = 1; stop = 1; flt = 1;
        end
      end else if (op == OP_HALT) begin
        eh = 1; stop = 1;
      end
    end
    #2;
    chk("branch", 32'(Branch), 32'(eb));
    chk("target", 32'(Target), 32'(et));
    chk("halt",   32'(Halt),   32'(eh));
    chk("done",   32'(Done),   32'(mdone));
    chk("fault",  32'(Fault),  32'(mfault));
    @(posedge CLK);
    if (ini) begin
      ms = M_IDLE; stk.delete(); mfault = 0; mdone = 0; mpc = 8'h00;
    end else begin
      if (ms == M_IDLE) begin
        if (st) ms = M_RUN;
      end else if (ms == M_RUN) begin
        if (push) stk.push_back(mpc + 8'd1);
        if (pop) void'(stk.pop_back());
        if (stop) begin
          ms = M_HALT; mdone = 1;
          if (flt) mfault = 1;
        end
      end
      if (eb) mpc = et;
      else if (!eh) mpc = mpc + 8'd1;
    end
    @(negedge CLK);
  endtask

  initial begin
    bit         ini, st, z;
    logic [3:0] op;
    int         k;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    // reset state seen on an Init cycle, then in IDLE
    cyc(1, 0, NOP, 5'd0, 0);
    cyc(0, 0, NOP, 5'd0, 0);
    // start, straight-line code
    cyc(0, 1, NOP, 5'd0, 0);
    repeat (4) cyc(0, 0, NOP, 5'd7, 0);
    // BZ idx 3 at PC 5, taken and not taken
    mpc = 8'h05; cyc(0, 0, OP_BZ, 5'd3, 1);
    mpc = 8'h05; cyc(0, 0, OP_BZ, 5'd3, 0);
    cyc(0, 0, OP_JMP, 5'd19, 0);
    // call/return, then RET on empty stack
    mpc = 8'h10; cyc(0, 0, OP_CALL, 5'd2, 0);
    cyc(0, 0, OP_RET, 5'd0, 0);
    cyc(0, 0, NOP, 5'd0, 0);
    cyc(0, 0, OP_RET, 5'd0, 0);
    cyc(0, 0, NOP, 5'd0, 0);
    cyc(1, 0, NOP, 5'd0, 0);
    // stack overflow on the fifth nested CALL
    cyc(0, 1, NOP, 5'd0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, OP_CALL, 5'(i + 8), 0);
    cyc(0, 0, NOP, 5'd0, 0);
    cyc(1, 0, NOP, 5'd0, 0);
    // HALT at 0x22, later Start ignored
    cyc(0, 1, NOP, 5'd0, 0);
    mpc = 8'h22; cyc(0, 0, OP_HALT, 5'd0, 0);
    cyc(0, 0, NOP, 5'd0, 0);
    cyc(0, 1, NOP, 5'd0, 0);
    cyc(0, 0, OP_JMP, 5'd1, 0);
    cyc(1, 0, NOP, 5'd0, 0);
    // Init mid-RUN with sp=2, then Init with Start held
    cyc(0, 1, NOP, 5'd0, 0);
    cyc(0, 0, OP_CALL, 5'd4, 0);
    cyc(0, 0, OP_CALL, 5'd5, 0);
    cyc(1, 0, OP_CALL, 5'd6, 0);
    cyc(0, 0, NOP, 5'd0, 0);
    cyc(0, 0, OP_RET, 5'd0, 0);
    cyc(0, 1, NOP, 5'd0, 0);
    cyc(0, 0, OP_CALL, 5'd4, 0);
    cyc(0, 0, OP_CALL, 5'd5, 0);
    cyc(1, 1, OP_CALL, 5'd6, 0);
    cyc(0, 0, OP_JMP, 5'd2, 0);
    cyc(0, 1, NOP, 5'd0, 0);
    cyc(0, 0, OP_RET, 5'd0, 0);
    cyc(1, 0, NOP, 5'd0, 0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      ini = ($urandom_range(0, 99) < 3);
      if (ms == M_IDLE) st = ($urandom_range(0, 2) == 0);
      else st = ($urandom_range(0, 9) == 0);
      z = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 23);
      if (k < 3) op = OP_BZ;
      else if (k < 5) op = OP_JMP;
      else if (k < 9) op = OP_CALL;
      else if (k < 13) op = OP_RET;
      else if (k == 23) op = OP_HALT;
      else if (k == 22) op = NOP;
      else op = 4'($urandom_range(5, 14));
      cyc(ini, st, op, 5'($urandom_range(0, 31)), z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Next-PC control unit at the opposite end of the fetch interface: it consumes the current `PC` and the instruction fetched at that `PC`, and drives the fetch unit's `Branch`, `Target` and `Halt` inputs. It resolves conditional and unconditional jumps through a shared target lookup table. It keeps a small return-address stack for call/return and sequences processor start and stop. It sits between the instruction ROM/ALU flags and the fetch unit, and shares `CLK` and `Init` with it.

## Interface
- `DEPTH`, 4: return-stack entries (2..8).
- `CLK`  in  1  system clock; all state updates on rising edge.
- `Init`  in  1  synchronous active-high reset; same net that zeroes the fetch unit's PC.
- `Start`  in  1  one-cycle pulse; begins execution from PC 0.
- `PC`  in  8  current program counter from the fetch unit.
- `Instr`  in  9  instruction at `PC` (combinational ROM read).
- `Zero`  in  1  ALU zero flag, valid in the same cycle as `Instr`.
- `Branch`  out  1  redirect fetch to `Target` at the next edge.
- `Target`  out  8  redirect address.
- `Halt`  out  1  hold the fetch unit's PC.
- `Done`  out  1  program completed (HALTED state).
- `Fault`  out  1  sticky: stack overflow or underflow occurred.

## Operation
- Control decode uses `Instr[8:5]` as the op and `Instr[4:0]` as `idx`. Ops:
  - `BZ`: branch if `Zero`.
  - `JMP`: unconditional branch.
  - `CALL`: branch and push.
  - `RET`: branch to the popped address.
  - `HALT`: stop.
  - Any other op is non-control and gives `Branch`=0.
- LUT target is `lut_target(idx)`, a 32-entry × 8-bit constant function.
- FSM states: IDLE, RUN, HALTED.
  - IDLE: `Halt`=1, `Branch`=0. On `Start`, go to RUN.
  - RUN: decode is active. A `HALT` op raises `Halt`=1 in the same cycle and goes to HALTED at the next edge.
  - HALTED: `Halt`=1, `Done`=1. Exit only via `Init`.
- `Start` outside IDLE is ignored.
- Behaviour in RUN, per op:
  - `BZ` with `Zero`=1: `Branch`=1, `Target`=`lut_target(idx)`.
  - `BZ` with `Zero`=0: `Branch`=0.
  - `JMP`: `Branch`=1, `Target`=`lut_target(idx)`.
  - `CALL`:
    - Not full: `Branch`=1, `Target`=`lut_target(idx)`; push `PC+1` (mod 256) at the edge.
    - Full: `Branch`=0, `Halt`=1, set `Fault`, go to HALTED. No push.
  - `RET`:
    - Not empty: `Branch`=1, `Target`=top of stack; pop at the edge.
    - Empty: `Branch`=0, `Halt`=1, set `Fault`, go to HALTED.
- Stack: `DEPTH` entries × 8 bits, pointer `sp` of width `$clog2(DEPTH+1)`. Empty when `sp`=0, full when `sp`=`DEPTH`. Entries are not cleared on pop.
- `Init` at any time, including mid-RUN or mid-CALL:
  - `sp`=0, `Fault`=0, state IDLE.
  - Outputs `Branch`=0, `Target`=0, `Halt`=1, `Done`=0.
  - `Init` overrides `Start` in the same cycle.
- `Target` is 0 whenever `Branch`=0.

## Timing
- `Branch`, `Target` and `Halt` are combinational from `Instr`, `Zero`, state, `sp` and the stack top. Decode latency is zero: the fetch unit samples them at the same edge that ends the instruction's cycle.
- Stack push/pop, `sp`, state and `Fault` update at the rising edge of the cycle in which the op is presented.
- Execution begins in the cycle after `Start` (RUN, `PC`=0).
- A `HALT` op at `PC`=n: `PC` holds at n from then on. `Done` rises one cycle after the `HALT` op is first presented.
- A `CALL` at the top of the stack followed by an immediate `RET` (one cycle later) returns to `PC+1` of the `CALL`. Push and pop never coincide because only one op executes per cycle.
- Reset values: `Branch`=0, `Target`=0, `Halt`=1, `Done`=0, `Fault`=0.

## Structure
- Package `pc_ctrl_pkg`:
  - 4-bit op constants `OP_BZ`, `OP_JMP`, `OP_CALL`, `OP_RET`, `OP_HALT`.
  - State enum `ctrl_state_t` {IDLE, RUN, HALTED}.
  - Function `lut_target(logic [4:0]) -> logic [7:0]`.
- One sub-module, `ret_stack`: parameter `DEPTH`; ports `CLK`, `Init`, `push`, `pop`, `din[7:0]`, `top[7:0]`, `full`, `empty`.
- Top level holds the FSM, decode and output muxing.

## Test plan
- Init then `Start`, with non-control ops → `Branch`=0 and `Halt`=0 for every cycle. `PC` advances 0,1,2,…
- `BZ` `idx`=3 at `PC`=5 (`lut_target(3)`=0x40):
  - `Zero`=1 → `Branch`=1, `Target`=0x40.
  - `Zero`=0 → `Branch`=0.
- `CALL` `idx`=2 at `PC`=0x10, then `RET` at the callee → `Target`=0x11 on the `RET` cycle, and `sp` returns to 0.
- Nested `CALL`s with `DEPTH`=4:
  - The fifth `CALL` → `Branch`=0, `Halt`=1, `Fault`=1, and `Done`=1 the next cycle.
  - `RET` on an empty stack → same response.
- `HALT` at `PC`=0x22 → `PC` stays 0x22, `Done`=1 after one cycle, and a later `Start` is ignored.
- `Init` asserted during RUN with `sp`=2, and again with `Start` held high in the same cycle → IDLE, `sp`=0, `Halt`=1, `Fault`=0. Execution resumes only on a later `Start`.
